// File: rtl/niosge_debug_pkg.sv
// Shared types for the debug system-clock bridge: action codes emitted to the
// core, instruction command classes and the scan-register decode.
package niosge_debug_pkg;

    typedef enum logic [3:0] {
        NONE           = 4'd0,
        OCIMEM_A       = 4'd1,
        OCIMEM_B       = 4'd2,
        NOACT_OCIMEM_A = 4'd3,
        BREAK_A        = 4'd4,
        BREAK_B        = 4'd5,
        BREAK_C        = 4'd6,
        NOACT_BREAK_A  = 4'd7,
        NOACT_BREAK_B  = 4'd8,
        NOACT_BREAK_C  = 4'd9,
        TRACECTRL      = 4'd10
    } act_code_e;

    localparam logic [1:0] CLS_OCIMEM = 2'd0;
    localparam logic [1:0] CLS_RSVD   = 2'd1;
    localparam logic [1:0] CLS_BREAK  = 2'd2;
    localparam logic [1:0] CLS_TRACE  = 2'd3;

    // top = {b37, b36, b35, b34}, the four most significant scan bits
    function automatic act_code_e decode_action(input logic [1:0] cls, input logic [3:0] top);
        act_code_e code;
        code = NONE;
        case (cls)
            CLS_OCIMEM: begin
                if (top[1])      code = OCIMEM_B;
                else if (top[0]) code = OCIMEM_A;
                else             code = NOACT_OCIMEM_A;
            end
            CLS_BREAK: begin
                if (top[2]) begin
                    if (top[3]) code = BREAK_C;
                    else        code = NOACT_BREAK_C;
                end else if (top[1]) begin
                    if (top[3]) code = BREAK_B;
                    else        code = NOACT_BREAK_B;
                end else begin
                    if (top[3]) code = BREAK_A;
                    else        code = NOACT_BREAK_A;
                end
            end
            CLS_TRACE: begin
                if (top[1]) code = TRACECTRL;
                else        code = NONE;
            end
            CLS_RSVD: code = NONE;
            default:  code = NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/niosge_debug_edge_sync.sv
// Brings a JTAG-domain level into clk and flags its low-to-high transitions.
// Every flop resets high so a level already high at reset release is not
// mistaken for a fresh edge.
module niosge_debug_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // synchroniser chain plus one delay flop for the edge compare
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            dly_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/niosge_debug_sysclk_bridge.sv
// System-clock side of the debug bridge. Update-IR latches the instruction,
// update-DR captures the scan register and turns it into a single pending
// action for the core, held until the core accepts it.
module niosge_debug_sysclk_bridge
    import niosge_debug_pkg::*;
#(
    parameter  int SR_W        = 38,
    parameter  int N_CH        = 1,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int IR_W        = 2 + CH_W
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_udr,
    input  logic            vs_uir,
    input  logic [IR_W-1:0] ir_in,
    input  logic [SR_W-1:0] sr,
    input  logic            act_ready,
    input  logic            ovr_clr,
    output logic [SR_W-1:0] jdo,
    output logic            act_valid,
    output logic [3:0]      act_code,
    output logic [CH_W-1:0] act_ch,
    output logic            st_overrun,
    output logic            st_bad_ch,
    output logic [7:0]      acc_cnt
);

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic            udr_rise;
    logic            uir_rise;
    logic [IR_W-1:0] ir_q;
    act_code_e       code_q;
    act_code_e       dec_code;
    logic [CH_W-1:0] ch;
    logic            ch_bad;
    logic            accept;
    logic            busy;
    logic            load;
    logic            set_ovr;
    logic            set_bad;

    niosge_debug_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    niosge_debug_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    // decode from the incoming scan value, i.e. what jdo is about to become
    assign ch       = ir_q[IR_W-1:2];
    assign ch_bad   = {1'b0, ch} >= N_CH_L;
    assign dec_code = decode_action(ir_q[1:0], sr[SR_W-1 -: 4]);

    // a pending action not being taken this cycle blocks a new capture
    assign accept  = act_valid & act_ready;
    assign busy    = act_valid & ~act_ready;
    assign load    = udr_rise & ~busy;
    assign set_ovr = udr_rise & busy;
    assign set_bad = load & ch_bad;

    // instruction latch, capture/handshake, acceptance counter and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q       <= '0;
            jdo        <= '0;
            act_valid  <= 1'b0;
            code_q     <= NONE;
            act_ch     <= '0;
            st_overrun <= 1'b0;
            st_bad_ch  <= 1'b0;
            acc_cnt    <= 8'd0;
        end else begin
            if (uir_rise) ir_q <= ir_in;
            if (load) begin
                jdo       <= sr;
                act_valid <= ~ch_bad & (dec_code != NONE);
                code_q    <= ch_bad ? NONE : dec_code;
                act_ch    <= ch;
            end else if (accept) begin
                act_valid <= 1'b0;
            end
            if (accept) acc_cnt <= acc_cnt + 8'd1;
            st_overrun <= set_ovr | (st_overrun & ~ovr_clr);
            st_bad_ch  <= set_bad | (st_bad_ch & ~ovr_clr);
        end
    end

    assign act_code = code_q;

endmodule

// File: tb/tb_niosge_debug_sysclk_bridge.sv
// Two bridges (one channel, three channels) share all stimulus. A transaction
// model advances once per clock edge; loaded actions are queued and popped
// by a negedge monitor when the core handshake occurs.
module tb_niosge_debug_sysclk_bridge;

    localparam int SR_W = 38;
    localparam int SYNC = 2;

    typedef struct packed {
        logic [3:0]      code;
        logic [1:0]      ch;
        logic [SR_W-1:0] jdo;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            vs_udr;
    logic            vs_uir;
    logic [3:0]      ir_v;
    logic [SR_W-1:0] sr_v;
    logic            act_ready;
    logic            ovr_clr;

    logic [SR_W-1:0] jdo0, jdo1;
    logic            av0, av1, ovr0, ovr1, bad0, bad1;
    logic [3:0]      code0, code1;
    logic [0:0]      ch0;
    logic [1:0]      ch1;
    logic [7:0]      cnt0, cnt1;

    int n_checks = 0;
    int n_pass   = 0;

    bit              m_valid [2];
    logic [SR_W-1:0] m_jdo   [2];
    bit              m_ovr   [2];
    bit              m_bad   [2];
    int              m_cnt   [2];
    logic [3:0]      m_ir;
    bit              prev_udr, prev_uir;
    int              edge_n;
    int              udr_due[$];
    int              uir_due[$];
    exp_t            sb0[$];
    exp_t            sb1[$];

    always #5 clk = ~clk;

    niosge_debug_sysclk_bridge #(.SR_W(SR_W), .N_CH(1), .SYNC_STAGES(SYNC)) dut0 (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_v[2:0]), .sr(sr_v), .act_ready(act_ready), .ovr_clr(ovr_clr),
        .jdo(jdo0), .act_valid(av0), .act_code(code0), .act_ch(ch0),
        .st_overrun(ovr0), .st_bad_ch(bad0), .acc_cnt(cnt0)
    );

    niosge_debug_sysclk_bridge #(.SR_W(SR_W), .N_CH(3), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_v), .sr(sr_v), .act_ready(act_ready), .ovr_clr(ovr_clr),
        .jdo(jdo1), .act_valid(av1), .act_code(code1), .act_ch(ch1),
        .st_overrun(ovr1), .st_bad_ch(bad1), .acc_cnt(cnt1)
    );

    task automatic chk(input string name, input int d, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, got, want, $time);
    endtask

    function automatic logic [SR_W-1:0] rand_sr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[SR_W-1:0];
    endfunction

    // action code from command class and {b37,b36,b35,b34}
    function automatic int exp_code(input logic [1:0] cls, input logic [3:0] b);
        int oci_tab[4];
        int brk_tab[8];
        oci_tab = '{3, 1, 2, 2};
        brk_tab = '{7, 8, 9, 9, 4, 5, 6, 6};
        case (cls)
            2'd0:    return oci_tab[b[1:0]];
            2'd2:    return brk_tab[b[3:1]];
            2'd3:    return b[1] ? 10 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int ch_of(input int d);
        if (d == 0) return int'(m_ir[2]);
        return int'(m_ir[3:2]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0;
            m_jdo[d]   = '0;
            m_ovr[d]   = 0;
            m_bad[d]   = 0;
            m_cnt[d]   = 0;
        end
        m_ir     = '0;
        prev_udr = 1;
        prev_uir = 1;
        udr_due.delete();
        uir_due.delete();
        sb0.delete();
        sb1.delete();
    endtask

    // effect of the clock edge that just happened, using the inputs it saw
    task automatic model_edge();
        bit fire_udr, fire_uir;
        fire_udr = 0;
        fire_uir = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        edge_n++;
        if (vs_udr && !prev_udr) udr_due.push_back(edge_n + SYNC);
        if (vs_uir && !prev_uir) uir_due.push_back(edge_n + SYNC);
        prev_udr = vs_udr;
        prev_uir = vs_uir;
        if (udr_due.size() > 0 && udr_due[0] == edge_n) begin
            void'(udr_due.pop_front());
            fire_udr = 1;
        end
        if (uir_due.size() > 0 && uir_due[0] == edge_n) begin
            void'(uir_due.pop_front());
            fire_uir = 1;
        end
        for (int d = 0; d < 2; d++) begin
            int   ch, code;
            bit   acc, set_o, set_b;
            exp_t e;
            ch    = ch_of(d);
            code  = exp_code(m_ir[1:0], sr_v[SR_W-1 -: 4]);
            acc   = m_valid[d] && act_ready;
            set_o = 0;
            set_b = 0;
            if (fire_udr) begin
                if (m_valid[d] && !act_ready) begin
                    set_o = 1;
                end else begin
                    m_jdo[d] = sr_v;
                    if (ch >= ((d == 0) ? 1 : 3)) begin
                        set_b      = 1;
                        m_valid[d] = 0;
                    end else if (code == 0) begin
                        m_valid[d] = 0;
                    end else begin
                        m_valid[d] = 1;
                        e.code = 4'(code);
                        e.ch   = 2'(ch);
                        e.jdo  = sr_v;
                        if (d == 0) sb0.push_back(e);
                        else        sb1.push_back(e);
                    end
                end
            end else if (acc) begin
                m_valid[d] = 0;
            end
            if (acc) m_cnt[d] = (m_cnt[d] + 1) % 256;
            m_ovr[d] = set_o || (m_ovr[d] && !ovr_clr);
            m_bad[d] = set_b || (m_bad[d] && !ovr_clr);
        end
        if (fire_uir) m_ir = ir_v;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_edge();
        end
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        tick(n);
        reset_n = 1'b1;
    endtask

    task automatic udr_pulse();
        vs_udr = 1'b1;
        tick(1);
        vs_udr = 1'b0;
        tick(1);
    endtask

    task automatic load_ir(input logic [3:0] ir);
        ir_v   = ir;
        vs_uir = 1'b1;
        tick(1);
        vs_uir = 1'b0;
        tick(3);
    endtask

    task automatic mon(input int d, input logic av, input logic [SR_W-1:0] jdo, input logic [3:0] code,
                       input logic [1:0] ch, input logic ovr, input logic bad, input logic [7:0] cnt);
        exp_t e;
        int   depth;
        chk("act_valid", d, 64'(av), 64'(m_valid[d]));
        chk("jdo", d, 64'(jdo), 64'(m_jdo[d]));
        chk("st_overrun", d, 64'(ovr), 64'(m_ovr[d]));
        chk("st_bad_ch", d, 64'(bad), 64'(m_bad[d]));
        chk("acc_cnt", d, 64'(cnt), 64'(m_cnt[d]));
        if (av && act_ready) begin
            depth = (d == 0) ? sb0.size() : sb1.size();
            chk("sb_depth", d, 64'(depth), 64'd1);
            if (depth > 0) begin
                if (d == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk("act_code", d, 64'(code), 64'(e.code));
                chk("act_ch", d, 64'(ch), 64'(e.ch));
                chk("hs_jdo", d, 64'(jdo), 64'(e.jdo));
            end
        end
    endtask

    // compare both bridges against the model away from the active edge
    always @(negedge clk) begin
        mon(0, av0, jdo0, code0, {1'b0, ch0}, ovr0, bad0, cnt0);
        mon(1, av1, jdo1, code1, ch1, ovr1, bad1, cnt1);
    end

    initial begin
        logic [SR_W-1:0] held;
        reset_n   = 1'b0;
        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        ir_v      = 4'd0;
        sr_v      = '0;
        act_ready = 1'b0;
        ovr_clr   = 1'b0;
        edge_n    = 0;
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(2);
        chk("rst_jdo", 0, 64'(jdo0), 64'd0);
        chk("rst_valid", 0, 64'(av0), 64'd0);
        chk("rst_code", 0, 64'(code0), 64'd0);

        // break A with the core ready: one-cycle pulse two edges after sampling
        load_ir(4'b0010);
        sr_v = rand_sr();
        sr_v[SR_W-1 -: 4] = 4'b1000;
        act_ready = 1'b1;
        udr_pulse();
        chk("break_a_early", 0, 64'(av0), 64'd0);
        tick(1);
        chk("break_a_valid", 0, 64'(av0), 64'd1);
        chk("break_a_code", 0, 64'(code0), 64'd4);
        chk("break_a_jdo", 0, 64'(jdo0), 64'(sr_v));
        tick(1);
        chk("break_a_once", 0, 64'(av0), 64'd0);
        chk("break_a_cnt", 0, 64'(cnt0), 64'd1);

        // OCIMEM_B held while the core stalls, then an overrun
        act_ready = 1'b0;
        load_ir(4'b0000);
        sr_v = rand_sr();
        sr_v[35] = 1'b1;
        udr_pulse();
        tick(1);
        held = sr_v;
        repeat (10) begin
            chk("ocib_hold", 0, 64'(av0), 64'd1);
            chk("ocib_code", 0, 64'(code0), 64'd2);
            tick(1);
        end
        sr_v = rand_sr();
        udr_pulse();
        tick(1);
        chk("ovr_set", 0, 64'(ovr0), 64'd1);
        chk("ovr_jdo", 0, 64'(jdo0), 64'(held));
        chk("ovr_valid", 0, 64'(av0), 64'd1);
        vs_udr = 1'b1;
        tick(1);
        vs_udr = 1'b0;
        tick(1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        chk("ovr_clr_set_wins", 0, 64'(ovr0), 64'd1);
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        chk("ovr_cleared", 0, 64'(ovr0), 64'd0);
        act_ready = 1'b1;
        tick(2);
        chk("ocib_accept_cnt", 0, 64'(cnt0), 64'd2);

        // channel 1: invalid on the single-channel bridge, valid on the other
        act_ready = 1'b0;
        load_ir(4'b0110);
        sr_v = rand_sr();
        sr_v[SR_W-1 -: 4] = 4'b1000;
        udr_pulse();
        tick(1);
        chk("badch_flag", 0, 64'(bad0), 64'd1);
        chk("badch_valid", 0, 64'(av0), 64'd0);
        chk("badch_jdo", 0, 64'(jdo0), 64'(sr_v));
        chk("ch1_valid", 1, 64'(av1), 64'd1);
        chk("ch1_ch", 1, 64'(ch1), 64'd1);
        chk("ch1_bad", 1, 64'(bad1), 64'd0);
        act_ready = 1'b1;
        ovr_clr   = 1'b1;
        tick(1);
        ovr_clr   = 1'b0;
        act_ready = 1'b0;
        chk("badch_clr", 0, 64'(bad0), 64'd0);
        load_ir(4'b1110);
        sr_v = rand_sr();
        udr_pulse();
        tick(1);
        chk("ch3_bad", 1, 64'(bad1), 64'd1);
        chk("ch3_valid", 1, 64'(av1), 64'd0);

        // class 1 only captures data
        load_ir(4'b0001);
        sr_v = rand_sr();
        udr_pulse();
        tick(1);
        chk("cls1_jdo", 0, 64'(jdo0), 64'(sr_v));
        chk("cls1_valid", 0, 64'(av0), 64'd0);

        // reset while an action is pending, with update-DR held high across release
        load_ir(4'b0010);
        sr_v = rand_sr();
        sr_v[SR_W-1 -: 4] = 4'b1101;
        udr_pulse();
        tick(1);
        chk("mid_pending", 0, 64'(av0), 64'd1);
        vs_udr = 1'b1;
        do_reset(3);
        tick(6);
        chk("rst_hs_valid", 0, 64'(av0), 64'd0);
        chk("rst_hs_cnt", 0, 64'(cnt0), 64'd0);
        chk("udr_high_jdo", 0, 64'(jdo0), 64'd0);
        vs_udr = 1'b0;
        tick(2);

        // counter wrap
        load_ir(4'b0010);
        sr_v[SR_W-1 -: 4] = 4'b1010;
        act_ready = 1'b1;
        repeat (255) udr_pulse();
        tick(2);
        chk("cnt_255", 0, 64'(cnt0), 64'd255);
        udr_pulse();
        tick(2);
        chk("cnt_wrap", 0, 64'(cnt0), 64'd0);
        chk("cnt_wrap", 1, 64'(cnt1), 64'd0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) vs_udr = ~vs_udr;
            vs_uir = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) ir_v = 4'($urandom());
            if ($urandom_range(0, 2) == 0) sr_v = rand_sr();
            act_ready = ($urandom_range(0, 2) != 0);
            ovr_clr   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 399) == 0) do_reset(2);
            else tick(1);
        end

        vs_udr    = 1'b0;
        vs_uir    = 1'b0;
        ovr_clr   = 1'b0;
        act_ready = 1'b1;
        tick(6);
        chk("sb_drain", 0, 64'(sb0.size()), 64'd0);
        chk("sb_drain", 1, 64'(sb1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/niosge_debug_sysclk_bridge.md
NIOSGE_DEBUG_SYSCLK_BRIDGE -- requirements
Module: niosge_debug_sysclk_bridge

Interface
REQ-001 SHALL have parameter SR_W, default 38, min 8: debug scan-register / jdo width.
REQ-002 SHALL have parameter N_CH, default 1: number of debug channels (CPU cores).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, min 2: synchroniser depth.
REQ-004 SHALL derive CH_W = max(1, clog2(N_CH)) and IR_W = 2 + CH_W; not overridable.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  system clock; reset_n  in  1  async active-low reset.
REQ-006 vs_udr  in  1  update-DR level from JTAG domain, asynchronous to clk.
REQ-007 vs_uir  in  1  update-IR level from JTAG domain, asynchronous to clk.
REQ-008 ir_in  in  IR_W  instruction; [1:0] = command class, [IR_W-1:2] = channel.
REQ-009 sr  in  SR_W  scan register; stable from vs_udr rise until next shift.
REQ-010 act_ready  in  1  core accepts pending action.
REQ-011 ovr_clr  in  1  one-cycle clear of sticky status flags.
REQ-012 jdo  out  SR_W  captured scan data.
REQ-013 act_valid  out  1  action pending.
REQ-014 act_code  out  4  action code (package enum).
REQ-015 act_ch  out  CH_W  target channel.
REQ-016 st_overrun / st_bad_ch  out  1 each  sticky status.
REQ-017 acc_cnt  out  8  accepted-action counter.

Function
REQ-018 vs_udr and vs_uir SHALL each pass through SYNC_STAGES flops and a rising-edge detector; only low-to-high transitions count.
REQ-019 uir edge SHALL latch ir_in into ir_q; udr edge in same cycle SHALL decode with previous ir_q.
REQ-020 udr edge sampled first at edge k SHALL load jdo<=sr and decoded outputs at edge k+SYNC_STAGES.
REQ-021 Decode uses b37..b34 = jdo[SR_W-1..SR_W-4] (new value). Class 0: b35 -> OCIMEM_B; else b34 -> OCIMEM_A; else NOACT_OCIMEM_A.
REQ-022 Class 2: b37=1 -> BREAK_x, b37=0 -> NOACT_BREAK_x; x = A if {b36,b35}=00, B if 01, C if 1x.
REQ-023 Class 3: b35=1 -> TRACECTRL, else NONE. Class 1: always NONE.
REQ-024 Code NONE SHALL update jdo but SHALL NOT assert act_valid.
REQ-025 Channel field >= N_CH SHALL set st_bad_ch, update jdo, not assert act_valid.
REQ-026 act_valid SHALL hold with act_code/act_ch/jdo stable until a clk edge with act_ready=1; it then deasserts and acc_cnt increments (255 wraps to 0).
REQ-027 New udr edge while act_valid=1 and act_ready=0: command dropped, jdo unchanged, st_overrun set.
REQ-028 New udr edge coinciding with acceptance: new command loads, act_valid stays 1, no overrun.
REQ-029 ovr_clr SHALL clear both sticky flags next edge; a simultaneous set SHALL win.

Reset
REQ-030 Reset SHALL clear jdo, act_valid, act_code (NONE), act_ch, ir_q, st_overrun, st_bad_ch, acc_cnt to 0.
REQ-031 Synchroniser and edge-detect flops SHALL reset to 1, so vs_udr/vs_uir held high across reset release produce no edge.
REQ-032 Reset mid-handshake SHALL discard the pending action with no acc_cnt increment.

Structure
REQ-033 Package niosge_debug_pkg SHALL hold act_code enum (NONE=0, OCIMEM_A=1, OCIMEM_B=2, NOACT_OCIMEM_A=3, BREAK_A=4, BREAK_B=5, BREAK_C=6, NOACT_BREAK_A=7, NOACT_BREAK_B=8, NOACT_BREAK_C=9, TRACECTRL=10) and class constants.
REQ-034 Sub-module niosge_debug_edge_sync (parameterised synchroniser + rising-edge detect) SHALL be instantiated twice.

Verification
REQ-035 uir with ir_in=0b010 (class 2, ch 0), then udr with sr[37:35]=100, act_ready=1 -> act_code=BREAK_A, act_valid one cycle, asserted 2 edges after udr sample, acc_cnt=1.
REQ-036 act_ready=0, class 0, b35=1 -> act_valid held 10 cycles with OCIMEM_B; second udr -> st_overrun=1, jdo unchanged.
REQ-037 N_CH=2, ir_in channel bit=1 -> act_ch=1; N_CH=1 with channel bit=1 -> st_bad_ch=1, act_valid=0.
REQ-038 vs_udr high throughout reset release -> no act_valid, jdo=0.
REQ-039 256 accepted actions -> acc_cnt wraps to 0; ovr_clr with simultaneous overrun -> st_overrun stays 1.
REQ-040 Class 1 udr -> jdo=sr, act_valid stays 0.
